// File: rtl/signed_mac_accumulator_if.sv
// Operand and result handshake bundle for signed_mac_accumulator.
// master drives operands and out_ready; slave is the accumulator.
interface signed_mac_accumulator_if #(
    parameter int unsigned ACC_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [3:0]       A;
    logic signed [3:0]       B;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] ACC;
    logic                    ovf;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, ACC, ovf
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, ACC, ovf
    );
endinterface

// File: rtl/signed_mac_accumulator.sv
// Signed 4x4 multiply-accumulate over N_TERMS operand pairs, result via valid/ready.
// Define MAC_SATURATE_EN to clamp on overflow; otherwise the accumulator wraps.
module four_bit_signed_multiplier (
    input  logic signed [3:0] a,
    input  logic signed [3:0] b,
    output logic signed [7:0] p
);
    logic signed [7:0] a_ext;
    logic signed [7:0] b_ext;

    assign a_ext = {{4{a[3]}}, a};
    assign b_ext = {{4{b[3]}}, b};
    assign p     = a_ext * b_ext;
endmodule

module signed_mac_accumulator #(
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned N_TERMS = 4
) (
    input logic                     clk,
    input logic                     rst,
    signed_mac_accumulator_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    typedef enum logic {StAccum, StDone} state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        count_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    ovf_q;
    logic                    in_ready_q;
    logic                    out_valid_q;

    logic signed [7:0]       prod;
    logic signed [ACC_W:0]   prod_ext;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   sum_ext;
    logic                    sum_ovf;
    logic signed [ACC_W-1:0] acc_next;
    logic                    accept;

    four_bit_signed_multiplier u_mult (
        .a (bus.A),
        .b (bus.B),
        .p (prod)
    );

    // One guard bit: the top two bits of the sum disagree exactly on signed overflow.
    assign prod_ext = {{(ACC_W - 7){prod[7]}}, prod};
    assign acc_ext  = {acc_q[ACC_W-1], acc_q};
    assign sum_ext  = acc_ext + prod_ext;
    assign sum_ovf  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    assign accept   = bus.in_valid && in_ready_q;

`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

    always_comb begin
        acc_next = sum_ext[ACC_W-1:0];
        if (sum_ovf) begin
            acc_next = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    always_comb begin
        acc_next = sum_ext[ACC_W-1:0];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StAccum;
            count_q     <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (accept) begin
                        // First term loads directly, so no clear cycle between batches.
                        if (count_q == '0) begin
                            acc_q <= prod_ext[ACC_W-1:0];
                            ovf_q <= 1'b0;
                        end else begin
                            acc_q <= acc_next;
                            ovf_q <= ovf_q | sum_ovf;
                        end
                        if (count_q == LAST_CNT) begin
                            count_q     <= '0;
                            state_q     <= StDone;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q     <= StAccum;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ACC       = acc_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_signed_mac_accumulator.sv
// Bench for signed_mac_accumulator: 16-bit and 8-bit accumulators driven in lockstep,
// compared against a plain-arithmetic dot-product model (wrap or saturate per MAC_SATURATE_EN).
module tb_signed_mac_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [3:0] a_in = '0;
    logic signed [3:0] b_in = '0;

    int total = 0;
    int bad = 0;

    int op_a[4];
    int op_b[4];

    int     early;
    int     hold_bad;
    bit     res_vld;
    longint res_acc16;
    longint res_acc8;
    bit     res_ovf16;
    bit     res_ovf8;
    bit     post_ok;

    longint e16;
    longint e8;
    bit     eo16;
    bit     eo8;

    always #5 clk = ~clk;

    signed_mac_accumulator_if #(.ACC_W(16)) bus16 ();
    signed_mac_accumulator_if #(.ACC_W(8))  bus8 ();

    assign bus16.in_valid  = in_valid;
    assign bus16.A         = a_in;
    assign bus16.B         = b_in;
    assign bus16.out_ready = out_ready;
    assign bus8.in_valid   = in_valid;
    assign bus8.A          = a_in;
    assign bus8.B          = b_in;
    assign bus8.out_ready  = out_ready;

    signed_mac_accumulator #(.ACC_W(16), .N_TERMS(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    signed_mac_accumulator #(.ACC_W(8), .N_TERMS(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(15));
    endfunction

    // Dot product of op_a/op_b at width w, flagging any out-of-range partial sum.
    function automatic void model(input int w, output longint acc, output bit ovf);
        longint mx;
        longint mn;
        longint s;
        mx  = (longint'(1) << (w - 1)) - 1;
        mn  = -(longint'(1) << (w - 1));
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = longint'(op_a[i] * op_b[i]);
            if (i > 0) begin
                s = acc + s;
                if (s > mx || s < mn) begin
                    ovf = 1'b1;
`ifdef MAC_SATURATE_EN
                    s = (s > mx) ? mx : mn;
`else
                    s = (s > mx) ? s - (longint'(1) << w) : s + (longint'(1) << w);
`endif
                end
            end
            acc = s;
        end
    endfunction

    function automatic void expect_all();
        model(16, e16, eo16);
        model(8, e8, eo8);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one batch and records what the DUTs showed; the callers judge the record.
    task automatic run_batch(input int gap, input int hold);
        early    = 0;
        hold_bad = 0;
        out_ready = (hold == 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    a_in = rnd4();
                    b_in = rnd4();
                    step();
                end
            end
            if (bus16.in_ready !== 1'b1 || bus8.in_ready !== 1'b1) early++;
            in_valid = 1'b1;
            a_in = 4'(op_a[i]);
            b_in = 4'(op_b[i]);
            step();
            if (i < 3 && (bus16.out_valid !== 1'b0 || bus8.out_valid !== 1'b0)) early++;
        end
        res_vld   = (bus16.out_valid === 1'b1) && (bus8.out_valid === 1'b1);
        res_acc16 = longint'(bus16.ACC);
        res_acc8  = longint'(bus8.ACC);
        res_ovf16 = bus16.ovf;
        res_ovf8  = bus8.ovf;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a_in = rnd4();
            b_in = rnd4();
            step();
            if (bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0 ||
                longint'(bus16.ACC) !== res_acc16 || bus16.ovf !== res_ovf16 ||
                bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0 ||
                longint'(bus8.ACC) !== res_acc8 || bus8.ovf !== res_ovf8) hold_bad++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        post_ok = (bus16.out_valid === 1'b0) && (bus16.in_ready === 1'b1) &&
                  (bus8.out_valid === 1'b0) && (bus8.in_ready === 1'b1);
    endtask

    task automatic set_ops(input int a0, b0, a1, b1, a2, b2, a3, b3);
        op_a[0] = a0; op_b[0] = b0;
        op_a[1] = a1; op_b[1] = b1;
        op_a[2] = a2; op_b[2] = b2;
        op_a[3] = a3; op_b[3] = b3;
    endtask

    task automatic test_reset();
        total++; if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0) begin bad++;
            $display("FAIL reset_hs got rdy=%b vld=%b exp rdy=1 vld=0", bus16.in_ready, bus16.out_valid); end
        total++; if (bus16.ACC !== 16'sd0 || bus16.ovf !== 1'b0) begin bad++;
            $display("FAIL reset_acc got acc=%0d ovf=%b exp acc=0 ovf=0", bus16.ACC, bus16.ovf); end
        in_valid = 1'b1; a_in = 4'sd3; b_in = 4'sd2;
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (bus16.ACC !== 16'sd0 || bus8.ACC !== 8'sd0 || bus16.ovf !== 1'b0) begin bad++;
            $display("FAIL async_reset_acc got acc16=%0d acc8=%0d ovf=%b exp 0 0 0",
                     bus16.ACC, bus8.ACC, bus16.ovf); end
        total++; if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0) begin bad++;
            $display("FAIL async_reset_hs got rdy=%b vld=%b exp rdy=1 vld=0",
                     bus16.in_ready, bus16.out_valid); end
        #1 rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        set_ops(3, 2, -4, 5, 7, 7, -8, -8);
        expect_all();
        run_batch(0, 0);
        total++; if (early !== 0) begin bad++; $display("FAIL basic_early got=%0d exp=0", early); end
        total++; if (res_vld !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", res_vld); end
        total++; if (res_acc16 !== 99 || res_acc16 !== e16) begin bad++;
            $display("FAIL basic_acc16 got=%0d exp=%0d", res_acc16, e16); end
        total++; if (res_acc8 !== e8) begin bad++; $display("FAIL basic_acc8 got=%0d exp=%0d", res_acc8, e8); end
        total++; if (res_ovf16 !== 1'b0 || res_ovf8 !== 1'b0) begin bad++;
            $display("FAIL basic_ovf got=%b%b exp=00", res_ovf16, res_ovf8); end
        total++; if (post_ok !== 1'b1) begin bad++; $display("FAIL basic_handoff got=%b exp=1", post_ok); end
    endtask

    task automatic test_backpressure();
        set_ops(3, 2, -4, 5, 7, 7, -8, -8);
        expect_all();
        run_batch(0, 5);
        total++; if (res_vld !== 1'b1 || res_acc16 !== e16) begin bad++;
            $display("FAIL bp_result got vld=%b acc=%0d exp vld=1 acc=%0d", res_vld, res_acc16, e16); end
        total++; if (hold_bad !== 0) begin bad++; $display("FAIL bp_hold got=%0d exp=0", hold_bad); end
        total++; if (post_ok !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", post_ok); end
    endtask

    task automatic test_gaps();
        set_ops(3, 2, -4, 5, 7, 7, -8, -8);
        expect_all();
        run_batch(3, 0);
        total++; if (early !== 0 || res_acc16 !== e16 || res_acc8 !== e8) begin bad++;
            $display("FAIL gaps_acc got early=%0d acc16=%0d acc8=%0d exp 0 %0d %0d",
                     early, res_acc16, res_acc8, e16, e8); end
        set_ops(1, 1, 1, 1, 1, 1, 1, 1);
        expect_all();
        run_batch(1, 0);
        total++; if (res_acc16 !== 4 || res_acc8 !== 4 || res_ovf16 !== 1'b0) begin bad++;
            $display("FAIL gaps_second got acc16=%0d acc8=%0d ovf=%b exp 4 4 0",
                     res_acc16, res_acc8, res_ovf16); end
    endtask

    task automatic test_overflow();
        set_ops(-8, -8, -8, -8, -8, -8, -8, -8);
        expect_all();
        run_batch(0, 0);
        total++; if (res_acc8 !== e8 || res_ovf8 !== eo8 || eo8 !== 1'b1) begin bad++;
            $display("FAIL ovf_pos got acc=%0d ovf=%b exp acc=%0d ovf=%b", res_acc8, res_ovf8, e8, eo8); end
        total++; if (res_acc16 !== 256 || res_ovf16 !== 1'b0) begin bad++;
            $display("FAIL ovf_pos_wide got acc=%0d ovf=%b exp acc=256 ovf=0", res_acc16, res_ovf16); end
        set_ops(-8, 7, -8, 7, -8, 7, -8, 7);
        expect_all();
        run_batch(0, 2);
        total++; if (res_acc8 !== e8 || res_ovf8 !== 1'b1) begin bad++;
            $display("FAIL ovf_neg got acc=%0d ovf=%b exp acc=%0d ovf=1", res_acc8, res_ovf8, e8); end
        total++; if (hold_bad !== 0) begin bad++; $display("FAIL ovf_hold got=%0d exp=0", hold_bad); end
        set_ops(1, 1, 1, 1, 1, 1, 1, 1);
        expect_all();
        run_batch(0, 0);
        total++; if (res_acc8 !== 4 || res_ovf8 !== 1'b0) begin bad++;
            $display("FAIL ovf_clear got acc=%0d ovf=%b exp acc=4 ovf=0", res_acc8, res_ovf8); end
    endtask

    task automatic test_reset_mid_batch();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a_in = 4'sd7; b_in = 4'sd7;
            step();
        end
        in_valid = 1'b0;
        total++; if (bus16.ACC !== 16'sd98) begin bad++;
            $display("FAIL mid_partial got=%0d exp=98", bus16.ACC); end
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        step();
        total++; if (bus16.ACC !== 16'sd0 || bus16.in_ready !== 1'b1) begin bad++;
            $display("FAIL mid_reset got acc=%0d rdy=%b exp acc=0 rdy=1", bus16.ACC, bus16.in_ready); end
        set_ops(2, 3, 2, 3, 2, 3, 2, 3);
        expect_all();
        run_batch(0, 0);
        total++; if (early !== 0 || res_vld !== 1'b1) begin bad++;
            $display("FAIL mid_count got early=%0d vld=%b exp 0 1", early, res_vld); end
        total++; if (res_acc16 !== 24 || res_acc8 !== 24) begin bad++;
            $display("FAIL mid_acc got acc16=%0d acc8=%0d exp 24 24", res_acc16, res_acc8); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 4; i++) begin
                op_a[i] = int'($urandom_range(15)) - 8;
                op_b[i] = int'($urandom_range(15)) - 8;
            end
            expect_all();
            run_batch(int'($urandom_range(2)), int'($urandom_range(3)));
            total++; if (early !== 0 || res_vld !== 1'b1 || hold_bad !== 0 || post_ok !== 1'b1) begin bad++;
                $display("FAIL rand_hs[%0d] got early=%0d vld=%b hold=%0d post=%b exp 0 1 0 1",
                         n, early, res_vld, hold_bad, post_ok); end
            total++; if (res_acc16 !== e16 || res_ovf16 !== eo16) begin bad++;
                $display("FAIL rand_acc16[%0d] got %0d/%b exp %0d/%b", n, res_acc16, res_ovf16, e16, eo16); end
            total++; if (res_acc8 !== e8 || res_ovf8 !== eo8) begin bad++;
                $display("FAIL rand_acc8[%0d] got %0d/%b exp %0d/%b", n, res_acc8, res_ovf8, e8, eo8); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_overflow();
        test_reset_mid_batch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
